// File: rtl/uart_tx_fifo_if.sv
// uart_tx_fifo_if: valid/ready write channel from a producer into the UART TX FIFO.
interface uart_tx_fifo_if #(parameter int FRAME_WD = 8);
   logic                tx_valid;
   logic                tx_ready;
   logic [FRAME_WD-1:0] tx_data;
   modport master (output tx_valid, output tx_data, input tx_ready);
   modport slave  (input tx_valid, input tx_data, output tx_ready);
endinterface

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: FIFO-fed UART transmitter, 5..9 data bits, optional parity, 1/2 stop bits.
// Define UART_TX_BREAK_EN to add the tx_break input and a line-break state.
module uart_tx_fifo #(
   parameter int    CLK_FREQUENCE = 50_000_000,
   parameter int    BAUD_RATE     = 9600,
   parameter string PARITY        = "NONE",
   parameter int    FRAME_WD      = 8,
   parameter int    STOP_BITS     = 1,
   parameter int    FIFO_DEPTH    = 4
) (
   input  logic                         clk,
   input  logic                         rst_n,
   uart_tx_fifo_if.slave                wr,
`ifdef UART_TX_BREAK_EN
   input  logic                         tx_break,
`endif
   output logic [$clog2(FIFO_DEPTH):0]  fifo_count,
   output logic                         tx_busy,
   output logic                         tx_done,
   output logic                         uart_tx
);
   localparam int BAUD_CNT = CLK_FREQUENCE / BAUD_RATE;
   localparam int BW       = BAUD_CNT > 1 ? $clog2(BAUD_CNT) : 1;
   localparam int AW       = $clog2(FIFO_DEPTH);
   localparam int CW       = AW + 1;
   localparam bit HAS_PAR  = PARITY != "NONE";
   localparam bit ODD_PAR  = PARITY == "ODD";

`ifdef UART_TX_BREAK_EN
   typedef enum logic [2:0] {IDLE, START, DATA, PAR_BIT, STOP, BREAK} state_t;
`else
   typedef enum logic [2:0] {IDLE, START, DATA, PAR_BIT, STOP} state_t;
`endif

   state_t              state_q, state_d;
   logic [BW-1:0]       baud_q, baud_d;
   logic [3:0]          bit_q, bit_d;
   logic [FRAME_WD-1:0] shift_q, shift_d;
   logic                par_q, par_d;
   logic                tx_q, tx_d;
   logic                done_q, done_d;
   logic [AW-1:0]       wr_q, wr_d, rd_q, rd_d;
   logic [CW-1:0]       cnt_q, cnt_d;
   logic [FRAME_WD-1:0] mem_q [FIFO_DEPTH];
   logic                ready, push, pop, launch, baud_end;

`ifdef UART_TX_BREAK_EN
   localparam int FRAME_CLKS = (1 + FRAME_WD + int'(HAS_PAR) + STOP_BITS) * BAUD_CNT;
   localparam int KW         = $clog2(FRAME_CLKS);
   logic          brk_q, brk_d;
   logic [KW-1:0] bcnt_q, bcnt_d;
   logic          bcnt_full;
   assign bcnt_full = bcnt_q == KW'(FRAME_CLKS - 1);
`endif

   // Ready depends on the count only, so a full FIFO refuses a write even on a pop edge.
   assign ready       = cnt_q < CW'(FIFO_DEPTH);
   assign wr.tx_ready = ready;
   assign push        = wr.tx_valid && ready;
   assign baud_end    = baud_q == BW'(BAUD_CNT - 1);
   assign fifo_count  = cnt_q;
   assign tx_busy     = state_q != IDLE;
   assign tx_done     = done_q;
   assign uart_tx     = tx_q;

   always_comb begin
      state_d = state_q;
      baud_d  = (state_q == IDLE || baud_end) ? '0 : baud_q + 1'b1;
      bit_d   = bit_q;
      shift_d = shift_q;
      par_d   = par_q;
      tx_d    = tx_q;
      done_d  = 1'b0;
      launch  = 1'b0;
      pop     = 1'b0;
`ifdef UART_TX_BREAK_EN
      brk_d   = brk_q;
      bcnt_d  = bcnt_q;
`endif
      case (state_q)
         IDLE:    launch = 1'b1;
         START:   if (baud_end) begin state_d = DATA; bit_d = '0; tx_d = shift_q[0]; end
         DATA:    if (baud_end) begin
            if (bit_q == 4'(FRAME_WD - 1)) begin
               state_d = HAS_PAR ? PAR_BIT : STOP;
               tx_d    = HAS_PAR ? par_q : 1'b1;
               bit_d   = '0;
            end else begin
               bit_d   = bit_q + 1'b1;
               shift_d = shift_q >> 1;
               tx_d    = shift_q[1];
            end
         end
         PAR_BIT: if (baud_end) begin state_d = STOP; tx_d = 1'b1; end
         STOP:    if (baud_end) begin
            if (bit_q != 4'(STOP_BITS - 1)) bit_d = bit_q + 1'b1;
`ifdef UART_TX_BREAK_EN
            else if (brk_q) begin state_d = IDLE; brk_d = 1'b0; end
`endif
            else begin done_d = 1'b1; launch = 1'b1; end
         end
`ifdef UART_TX_BREAK_EN
         BREAK: begin
            bcnt_d = bcnt_full ? bcnt_q : bcnt_q + 1'b1;
            if (bcnt_full && !tx_break) begin
               state_d = STOP;
               tx_d    = 1'b1;
               bit_d   = '0;
               baud_d  = '0;
               brk_d   = 1'b1;
            end
         end
`endif
         default: state_d = IDLE;
      endcase
      // A frame boundary (or idle) either starts the next queued word or parks the line high.
      if (launch) begin
`ifdef UART_TX_BREAK_EN
         if (tx_break) begin state_d = BREAK; tx_d = 1'b0; bcnt_d = '0; end else
`endif
         begin
            pop     = cnt_q != '0;
            state_d = pop ? START : IDLE;
            tx_d    = !pop;
         end
      end
      if (pop) begin
         shift_d = mem_q[rd_q];
         par_d   = ODD_PAR ^ (^mem_q[rd_q]);
      end
      wr_d  = push ? wr_q + 1'b1 : wr_q;
      rd_d  = pop ? rd_q + 1'b1 : rd_q;
      cnt_d = cnt_q + CW'(push) - CW'(pop);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         baud_q  <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         par_q   <= 1'b0;
         tx_q    <= 1'b1;
         done_q  <= 1'b0;
         wr_q    <= '0;
         rd_q    <= '0;
         cnt_q   <= '0;
`ifdef UART_TX_BREAK_EN
         brk_q   <= 1'b0;
         bcnt_q  <= '0;
`endif
      end else begin
         state_q <= state_d;
         baud_q  <= baud_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         par_q   <= par_d;
         tx_q    <= tx_d;
         done_q  <= done_d;
         wr_q    <= wr_d;
         rd_q    <= rd_d;
         cnt_q   <= cnt_d;
`ifdef UART_TX_BREAK_EN
         brk_q   <= brk_d;
         bcnt_q  <= bcnt_d;
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem_q[wr_q] <= wr.tx_data;
   end
endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
Parametrised successor to the single-frame UART transmitter. It adds a valid/ready write interface, an internal TX FIFO, selectable parity, 1 or 2 stop bits, and 5..9 bit frames. Queued frames are sent back-to-back with no idle gap between them. It sits between a host/bus-side producer and the serial pin.

Parameters:
CLK_FREQUENCE, 50_000_000, clock frequency in Hz
BAUD_RATE, 9600, line rate; BAUD_CNT = CLK_FREQUENCE/BAUD_RATE (integer division), clocks per bit
PARITY, "NONE", one of "NONE", "EVEN", "ODD"
FRAME_WD, 8, data bits per frame, legal 5..9
STOP_BITS, 1, legal 1 or 2
FIFO_DEPTH, 4, FIFO entries, power of 2, >= 2

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
tx_valid  in  1  producer has a word
tx_ready  out  1  FIFO can accept; combinational, = (fifo_count < FIFO_DEPTH)
tx_data  in  FRAME_WD  word to send, sampled when tx_valid && tx_ready
fifo_count  out  $clog2(FIFO_DEPTH)+1  words queued, excluding the frame in flight
tx_busy  out  1  high in any state other than IDLE
tx_done  out  1  one-cycle pulse at the end of each frame's last stop bit
uart_tx  out  1  serial line, registered, idle high

Behaviour:
- Interface: one clock (clk); asynchronous active-low reset (rst_n).
- Reset values: uart_tx=1, tx_done=0, tx_busy=0, fifo_count=0, FSM=IDLE, FIFO pointers=0. tx_ready is therefore 1 during reset.
- Write handshake: a word is accepted on an edge where tx_valid && tx_ready. When full, no write occurs that edge even if a pop happens (ready is count-based only).
- Simultaneous push and pop: count unchanged, both operations are performed.
- FSM states: IDLE, START, DATA, PARITY, STOP. Each non-IDLE state counts BAUD_CNT clocks per bit via baud_cnt 0..BAUD_CNT-1.
- IDLE: on an edge with FIFO non-empty, pop the head into the shift register and enter START. uart_tx goes low from that edge.
- Latency: a word accepted at edge E into an empty FIFO in IDLE gives a start bit driven from edge E+1.
- START: 1 bit low -> DATA.
- DATA: FRAME_WD bits, LSB first, bit counter 0..FRAME_WD-1. Then PARITY if PARITY != "NONE", else STOP.
- PARITY: EVEN drives ^data; ODD drives ~^data; computed over the FRAME_WD bits -> STOP.
- STOP: STOP_BITS bit periods high.
- At the end of the last stop-bit clock, tx_done pulses for 1 cycle.
  - If FIFO non-empty: pop and go directly to START (no idle gap).
  - Otherwise: go to IDLE.
- Frame length in clocks: (1 + FRAME_WD + (PARITY!="NONE") + STOP_BITS) * BAUD_CNT, exact.
- FIFO pointers wrap modulo FIFO_DEPTH. Ordering is strictly FIFO.
- Reset mid-frame: uart_tx returns high immediately (async), FIFO flushed, no tx_done.
- tx_data changes after acceptance do not affect queued or in-flight frames.

Optional Feature:
UART_TX_BREAK_EN
- Defined: adds input port tx_break (1 bit) and FSM state BREAK.
  - tx_break sampled high in IDLE -> BREAK: uart_tx low while tx_break is high, for a minimum of one full frame length.
  - After release: STOP_BITS bit periods high, then IDLE. No tx_done is issued for a break.
  - tx_break raised during a frame: the current frame completes first, and BREAK takes priority over a FIFO pop at the frame boundary.
  - The FIFO keeps accepting writes during BREAK.
- Undefined: no tx_break port, no BREAK state, behaviour exactly as above.

Test Plan:
All tests use CLK_FREQUENCE=1_000_000 and BAUD_RATE=100_000 (BAUD_CNT=10) unless noted.
- NONE parity, 1 stop, write 0x2B -> start low 10 clk; bits 1,1,0,1,0,1,0,0 at 10 clk each; stop high 10 clk; tx_done single pulse 100 clk after start; tx_busy low after.
- EVEN parity, write 0x35 -> parity bit 0. ODD parity -> parity bit 1. STOP_BITS=2 -> stop high 20 clk, frame 120 clk (with parity).
- tx_valid held with words 0x01..0x06, FIFO_DEPTH=4 -> five words accepted on consecutive edges; tx_ready low after the fifth; 0x06 accepted after the next pop; six frames back-to-back with no idle clock, in order.
- rst_n pulled low mid-DATA of a frame, with 2 words queued -> uart_tx=1 immediately, fifo_count=0, no tx_done; line stays idle after release.
- FRAME_WD=7, write 0x7F -> 9-bit frame (90 clk), seven 1 data bits; parity/stop placement correct.
- With UART_TX_BREAK_EN: tx_break high 50 clk in IDLE -> uart_tx low 100 clk (minimum frame), then high 10 clk. A word queued during the break starts only after that.
